mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: MultDiv

Interface
REQ-001 SHALL have no parameters; all data ports SHALL be `DATA_BUS` (32 bits) wide.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  EX-stage request to begin an operation; sampled only in IDLE.
REQ-006 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 operand_a  input  32  multiplicand / dividend (rs).
REQ-008 operand_b  input  32  multiplier / divisor (rt).
REQ-009 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-010 busy  output  1  stall request to the pipeline controller.
REQ-011 done  output  1  one-cycle pulse: results are valid.
REQ-012 hilo_write_en  output  1  HI/LO write strobe to the MEM stage; equals done.
REQ-013 hi_result  output  32  upper product half, or remainder.
REQ-014 lo_result  output  32  lower product half, or quotient.

Function
REQ-015 SHALL implement the FSM states IDLE, MUL, DIV and DONE.
REQ-016 In IDLE with start=1 and flush=0, the FSM SHALL latch op and operands; op MULT/MULTU go to MUL; op DIV/DIVU with operand_b≠0 go to DIV; with operand_b=0 they go to DONE.
REQ-017 MUL SHALL last one cycle, register the 64-bit product {hi,lo}, and go to DONE.
REQ-018 MULT SHALL treat operands as signed two's complement; MULTU SHALL treat them as unsigned.
REQ-019 DIV SHALL run a restoring radix-2 divide on operand magnitudes for exactly 32 cycles, with a 5-bit counter from 0 to 31, then go to DONE.
REQ-020 Signed DIV sign fix-up: quotient negated iff sign(a) XOR sign(b); remainder takes the sign of a.
REQ-021 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000 (two's-complement wrap, no trap).
REQ-022 Divide by zero (DIV or DIVU) SHALL give lo=0xFFFFFFFF and hi=operand_a, with no iterations.
REQ-023 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-024 busy SHALL be asserted combinationally when (state=IDLE and start=1 and flush=0), or state=MUL, or state=DIV; it SHALL be 0 in DONE.
REQ-025 Latency from the accepting edge to done high SHALL be: MUL 2 cycles; DIV/DIVU 33 cycles; divide by zero 1 cycle.
REQ-026 hi_result and lo_result SHALL be registered and SHALL hold their values from DONE until the next DONE.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 operand changes after acceptance SHALL have no effect on the operation in flight.
REQ-029 flush=1 in any state SHALL force IDLE at the next edge, with no done pulse and hi_result/lo_result unchanged.
REQ-030 flush=1 together with start=1 in IDLE SHALL not accept the request; busy SHALL stay 0.
REQ-031 In DONE, flush SHALL not suppress done, because the write already belongs to a committed instruction.

Reset
REQ-032 While rst=1 at a clock edge: state←IDLE, counter←0, hi_result←0, lo_result←0.
REQ-033 Outputs during and after reset SHALL be busy=0, done=0, hilo_write_en=0.
REQ-034 rst SHALL take priority over flush and start, and SHALL abort an operation in progress with no done pulse.

Verification
REQ-035 MULT a=0xFFFFFFFE, b=0x00000003 -> done 2 cycles after acceptance; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 MULTU a=0xFFFFFFFE, b=0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA; busy high for exactly 2 cycles (accept cycle + MUL).
REQ-037 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> done 33 cycles after acceptance; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002; DIVU a=5, b=0 -> done after 1 cycle, lo=0xFFFFFFFF, hi=0x00000005.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
REQ-040 DIVU 100/7 with flush at iteration 10 -> IDLE next cycle, busy=0, no done, previous results retained; same abort with rst instead -> hi/lo=0.

Source files
------------

// File: rtl/mult_div.sv
// Multi-cycle HI/LO unit: single-cycle multiply plus a 32-step restoring divider.
// Results are registered and held from one completed operation to the next.
`ifndef DATA_BUS
`define DATA_BUS 32
`endif

module mult_div (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [`DATA_BUS-1:0] operand_a,
  input  logic [`DATA_BUS-1:0] operand_b,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic                 hilo_write_en,
  output logic [`DATA_BUS-1:0] hi_result,
  output logic [`DATA_BUS-1:0] lo_result
);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [`DATA_BUS-1:0]   a_q, a_d;
  logic [`DATA_BUS-1:0]   b_q, b_d;
  logic [`DATA_BUS-1:0]   rem_q, rem_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [`DATA_BUS-1:0]   hi_q, hi_d;
  logic [`DATA_BUS-1:0]   lo_q, lo_d;
  logic                   done_q, done_d;

  logic                   in_signed;
  logic [`DATA_BUS-1:0]   mag_a, mag_b;
  logic                   mul_signed;
  logic [2*`DATA_BUS-1:0] ext_a, ext_b, product;
  logic [`DATA_BUS:0]     shifted, diff;
  logic [`DATA_BUS-1:0]   quo_next, rem_next;

  // During DIV, a_q is the dividend shifting out and the quotient shifting in; b_q is |divisor|.
  always_comb begin
    in_signed  = (op == OP_DIV);
    mag_a      = (in_signed && operand_a[`DATA_BUS-1]) ? -operand_a : operand_a;
    mag_b      = (in_signed && operand_b[`DATA_BUS-1]) ? -operand_b : operand_b;

    mul_signed = (op_q == OP_MULT);
    ext_a      = {{`DATA_BUS{mul_signed & a_q[`DATA_BUS-1]}}, a_q};
    ext_b      = {{`DATA_BUS{mul_signed & b_q[`DATA_BUS-1]}}, b_q};
    product    = ext_a * ext_b;

    shifted    = {rem_q, a_q[`DATA_BUS-1]};
    diff       = shifted - {1'b0, b_q};
    if (!diff[`DATA_BUS]) begin
      rem_next = diff[`DATA_BUS-1:0];
      quo_next = {a_q[`DATA_BUS-2:0], 1'b1};
    end else begin
      rem_next = shifted[`DATA_BUS-1:0];
      quo_next = {a_q[`DATA_BUS-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d = op;
          cnt_d = 5'd0;
          rem_d = '0;
          if (op == OP_MULT || op == OP_MULTU) begin
            a_d = operand_a;
            b_d = operand_b;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d = MUL;
          end else if (operand_b == '0) begin
            a_d = operand_a;
            b_d = operand_b;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            hi_d = operand_a;
            lo_d = '1;
            state_d = DONE;
          end else begin
            a_d = mag_a;
            b_d = mag_b;
            neg_quo_d = in_signed & (operand_a[`DATA_BUS-1] ^ operand_b[`DATA_BUS-1]);
            neg_rem_d = in_signed & operand_a[`DATA_BUS-1];
            state_d = DIV;
          end
        end
      end
      MUL: begin
        hi_d = product[2*`DATA_BUS-1:`DATA_BUS];
        lo_d = product[`DATA_BUS-1:0];
        state_d = DONE;
      end
      DIV: begin
        a_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          lo_d = neg_quo_q ? -quo_next : quo_next;
          hi_d = neg_rem_q ? -rem_next : rem_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush in DONE changes nothing: that write already belongs to a committed instruction.
    if (flush && state_q != DONE) begin
      state_d = IDLE;
      cnt_d = 5'd0;
      hi_d = hi_q;
      lo_d = lo_q;
    end

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= 5'd0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = ~rst & ((state_q == IDLE && start && !flush) ||
                        state_q == MUL || state_q == DIV);
  assign done          = done_q & ~rst;
  assign hilo_write_en = done;
  assign hi_result     = hi_q;
  assign lo_result     = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases, randomized operations against an
// arithmetic reference model, and flush/reset aborts.
module tb_mult_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        flush;
  logic        busy;
  logic        done;
  logic        hilo_write_en;
  logic [31:0] hi_result;
  logic [31:0] lo_result;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] expHi = 32'h0;
  logic [31:0] expLo = 32'h0;

  mult_div dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .operand_a(operandA),
    .operand_b(operandB),
    .flush(flush),
    .busy(busy),
    .done(done),
    .hilo_write_en(hilo_write_en),
    .hi_result(hi_result),
    .lo_result(lo_result)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference results computed with plain wide arithmetic.
  task automatic refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'(sa * sb);
        hi = p[63:32]; lo = p[31:0]; lat = 2;
      end
      2'b01: begin
        p = {32'h0, a} * {32'h0, b};
        hi = p[63:32]; lo = p[31:0]; lat = 2;
      end
      default: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFF_FFFF; lat = 1;
        end else if (o == 2'b10) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
          lat = 33;
        end else begin
          lo = a / b; hi = a % b; lat = 33;
        end
      end
    endcase
  endtask

  // Issue one operation, optionally holding start high while busy, and check timing and results.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic holdStart);
    logic [31:0] rHi, rLo;
    int          lat, cycles;
    refModel(o, a, b, rHi, rLo, lat);
    @(negedge clk);
    op = o; operandA = a; operandB = b; start = 1'b1;
    #1;
    checkOutput("busy_accept", 64'(busy), 64'(1));
    @(negedge clk);
    start = holdStart;
    operandA = $urandom;
    operandB = $urandom;
    op = 2'($urandom_range(0, 3));
    cycles = 1;
    checkOutput("busy_running", 64'(busy), 64'(lat > 1));
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checkOutput("latency", 64'(cycles), 64'(lat));
    checkOutput("hilo_write_en", 64'(hilo_write_en), 64'(1));
    checkOutput("busy_in_done", 64'(busy), 64'(0));
    checkOutput("hi_result", 64'(hi_result), 64'(rHi));
    checkOutput("lo_result", 64'(lo_result), 64'(rLo));
    expHi = rHi;
    expLo = rLo;
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'(0));
    checkOutput("hi_hold", 64'(hi_result), 64'(expHi));
    checkOutput("lo_hold", 64'(lo_result), 64'(expLo));
  endtask

  // Abort DIVU 100/7 at iteration 10 with either flush or reset.
  task automatic abortDivide(input logic useRst);
    logic sawDone;
    @(negedge clk);
    op = 2'b11; operandA = 32'd100; operandB = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    if (useRst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    if (useRst) begin
      expHi = 32'h0;
      expLo = 32'h0;
    end
    checkOutput(useRst ? "rst_abort_busy" : "flush_abort_busy", 64'(busy), 64'(0));
    checkOutput(useRst ? "rst_abort_done" : "flush_abort_done", 64'(done), 64'(0));
    checkOutput(useRst ? "rst_abort_hi" : "flush_abort_hi", 64'(hi_result), 64'(expHi));
    checkOutput(useRst ? "rst_abort_lo" : "flush_abort_lo", 64'(lo_result), 64'(expLo));
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) sawDone = 1'b1;
    end
    checkOutput(useRst ? "rst_no_done" : "flush_no_done", 64'(sawDone), 64'(0));
  endtask

  function automatic logic [31:0] pickOperand(input logic allowZero);
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return allowZero ? 32'h0 : 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Main sequence
  initial begin
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b00;
    operandA = 32'h1234; operandB = 32'h5678;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_hilo_we", 64'(hilo_write_en), 64'(0));
    checkOutput("reset_hi", 64'(hi_result), 64'(0));
    checkOutput("reset_lo", 64'(lo_result), 64'(0));
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_busy", 64'(busy), 64'(0));

    applyStimulus(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0);
    applyStimulus(2'b11, 32'd5, 32'd0, 1'b0);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(2'b10, 32'h8000_0000, 32'h0, 1'b0);

    // flush with start in IDLE must not accept a divide-by-zero that would finish next edge
    @(negedge clk);
    op = 2'b11; operandA = 32'd9; operandB = 32'd0; start = 1'b1; flush = 1'b1;
    #1;
    checkOutput("flush_start_busy", 64'(busy), 64'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("flush_start_done", 64'(done), 64'(0));
    checkOutput("flush_start_hi", 64'(hi_result), 64'(expHi));
    checkOutput("flush_start_lo", 64'(lo_result), 64'(expLo));

    abortDivide(1'b0);
    abortDivide(1'b1);

    for (int i = 0; i < 50; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(1'b0), pickOperand(1'b1),
                    1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
